vga_sync_receiver: RTL
======================

# vga_sync_receiver

- Receive end of the team's 640x480 VGA timing: accepts active-low hsync/vsync and 12-bit RGB, as driven by the display controller or an external source.
- Recovers pixel coordinates and display-area qualification, and measures line and frame lengths.
- Declares lock after consecutive conforming frames.
- Used for loopback verification of the display path and as a capture front end for downstream frame-processing blocks.

## Interface

Parameters:
- H_TOTAL, 800: pixel ticks per line.
- H_DISP_START, 144: first displayed h count, measured from hsync fall.
- H_DISP_END, 784: first non-displayed h count.
- V_TOTAL, 521: lines per frame.
- V_DISP_START, 31: first displayed line, measured from vsync fall.
- V_DISP_END, 511: first non-displayed line.
- LOCK_FRAMES, 2: consecutive good frames required for lock (range 1..15).

Ports:
- clk, input, 1: 50 MHz system clock.
- rst, input, 1: reset, asynchronous, active-high.
- clk_25MHz, input, 1: pixel-tick enable, one clk cycle high in every two.
- hsync_in, input, 1: horizontal sync, active low, asynchronous to clk.
- vsync_in, input, 1: vertical sync, active low, asynchronous to clk.
- rgb_in, input, 12: pixel colour, sampled alongside the syncs.
- x, output, 10: horizontal display address, 0..639.
- y, output, 9: vertical display address, 0..479.
- rgb_out, output, 12: captured pixel; 0 when pixel_valid is low.
- pixel_valid, output, 1: x/y/rgb_out describe a displayed pixel and the receiver is locked.
- frame_start, output, 1: one-clk pulse at each vsync-qualified line start.
- locked, output, 1: timing conforms.
- sync_error, output, 1: one-clk pulse when lock is lost.
- line_len, output, 10: ticks in the last completed line, saturated at 1023.
- frame_len, output, 10: lines in the last completed frame, saturated at 1023.
- checksum, output, 16: frame checksum (see Configuration).

## Operation

- Synchronisation: hsync_in, vsync_in and rgb_in pass through two clk flops every cycle. All remaining logic advances only on cycles where clk_25MHz = 1 (ticks).
- Horizontal:
  - An hsync fall is a tick on which synced hsync = 0 and the previous tick's sample was 1.
  - On an hsync fall, h_cnt <= 0. Otherwise h_cnt <= h_cnt + 1, saturating at 1023.
  - On an hsync fall, line_len <= h_cnt + 1, saturated at 1023.
- Vertical:
  - A vsync fall, detected the same way, sets vs_pend.
  - On an hsync fall with vs_pend = 1: v_cnt <= 0, frame_len <= v_cnt + 1 (saturated), frame_start pulses, and vs_pend clears.
  - On an hsync fall with vs_pend = 0: v_cnt <= v_cnt + 1, saturating at 1023.
  - A vsync fall and an hsync fall on the same tick count as vsync first.
- Display window: H_DISP_START <= h_cnt < H_DISP_END and V_DISP_START <= v_cnt < V_DISP_END. In the window, x = h_cnt - H_DISP_START and y = v_cnt - V_DISP_START.
- Lock FSM:
  - States: UNLOCKED, LOCKED.
  - A line is bad if line_len != H_TOTAL.
  - A frame is good if frame_len == V_TOTAL and it contained no bad line.
  - The first line and first frame after reset are unmeasured and never counted as good or bad.
  - UNLOCKED: each good frame increments good_cnt; any bad line or bad frame clears it. When good_cnt reaches LOCK_FRAMES, move to LOCKED on that frame_start.
  - LOCKED: a bad line or bad frame returns to UNLOCKED, clears good_cnt and pulses sync_error on the transition cycle.
- Outputs: x, y and rgb_out are registered together. pixel_valid = window && locked. When pixel_valid = 0, rgb_out = 0 and x/y hold their last values.

## Timing

- Reset values:
  - x = 0, y = 0, rgb_out = 0
  - pixel_valid = 0, frame_start = 0, locked = 0, sync_error = 0
  - line_len = 0, frame_len = 0, checksum = 0
  - FSM in UNLOCKED; h_cnt and v_cnt at 1023 (saturated); vs_pend = 0
- Latency:
  - rgb_in to rgb_out: 3 clk (2 sync stages plus 1 output register).
  - An hsync_in edge at a tick is acted on at the tick 2 clk later.
- locked rises in the same cycle as the frame_start that completes the LOCK_FRAMES-th good frame. pixel_valid can first assert at the next window entry.
- sync_error and the locked fall occur on the tick of the offending hsync fall (bad line) or frame_start (bad frame).
- Reset mid-frame: all state clears immediately. A full reacquisition is required, including the unmeasured first line and frame.

## Configuration

- VGA_RX_FRAME_CHECKSUM_EN defined:
  - A 16-bit accumulator adds {4'b0, rgb_out} on every pixel_valid cycle, wrapping mod 2^16.
  - At frame_start, checksum <= accumulator and the accumulator clears.
- Not defined: no accumulator is built and checksum is constant 0.

## Test plan

- Reset: assert rst mid-stream -> all outputs at their reset values within the same cycle, and locked stays 0 until 3 full frames after release.
- Nominal 800x521 stream, rgb_in = {h mod 16, v mod 16, 4'h5} -> line_len = 800, frame_len = 521, locked after frame 3. First pixel_valid has x = 0, y = 0, and exactly 307200 valid pixels occur per frame.
- One 799-tick line injected while locked -> line_len = 799, one-cycle sync_error, locked = 0, and relock 2 good frames later.
- Hsync stuck high for 1500 ticks -> h_cnt saturates, and the next fall gives line_len = 1023 and an error.
- Frame of 520 lines -> frame_len = 520, unlock at that frame_start; coincident vsync/hsync falls -> v_cnt = 0.
- With the macro defined, rgb_in = 12'h001 throughout -> checksum = 16'hB000 after a locked frame. Without the macro -> checksum = 0.

Source files
------------

// File: rtl/vga_sync_receiver.sv
`timescale 1ns/1ps
// vga_sync_receiver: receive side of the 640x480 VGA timing.
// Synchronises hsync/vsync/rgb into clk, recovers h/v counters on pixel ticks,
// measures line and frame lengths, qualifies the display window and tracks lock.
// Optional feature macro: VGA_RX_FRAME_CHECKSUM_EN (per-frame pixel checksum).
module vga_sync_receiver #(
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_DISP_START = 144,
    parameter int unsigned H_DISP_END   = 784,
    parameter int unsigned V_TOTAL      = 521,
    parameter int unsigned V_DISP_START = 31,
    parameter int unsigned V_DISP_END   = 511,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_25MHz,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [11:0] rgb_out,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_len,
    output logic [15:0] checksum
);

    localparam int unsigned CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'h3FF;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Synchroniser stages
    logic             r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2;
    logic [11:0]      r_rgb_s1, r_rgb_s2;

    // Timing recovery state
    logic             r_hs_prev, r_vs_prev, r_vs_pend;
    logic             r_line_meas, r_bad_line_seen;
    logic [1:0]       r_fs_seen;
    logic [CNT_W-1:0] r_h_cnt, r_v_cnt, r_line_len, r_frame_len;

    // Output registers
    logic [9:0]       r_x;
    logic [8:0]       r_y;
    logic [11:0]      r_rgb_out;
    logic             r_pixel_valid, r_frame_start;

    // Lock tracking
    state_t           r_state;
    logic [3:0]       r_good_cnt;
    logic             r_locked, r_sync_error;

    logic             w_hs_fall, w_vs_fall, w_fs;
    logic [CNT_W-1:0] w_h_inc, w_v_inc, w_h_next, w_v_next;
    logic             w_line_bad, w_frame_meas, w_frame_bad, w_frame_good;
    logic             w_in_win;
    logic [9:0]       w_x;
    logic [8:0]       w_y;
    logic [3:0]       w_good_inc;

    // Edge detection against the previous tick's sample; vsync counts first on a shared tick
    assign w_hs_fall = r_hs_prev & ~r_hs_s2;
    assign w_vs_fall = r_vs_prev & ~r_vs_s2;
    assign w_fs      = w_hs_fall & (r_vs_pend | w_vs_fall);

    // Saturating increments double as the new line/frame length
    assign w_h_inc  = (r_h_cnt == CNT_MAX) ? r_h_cnt : r_h_cnt + 10'd1;
    assign w_v_inc  = (r_v_cnt == CNT_MAX) ? r_v_cnt : r_v_cnt + 10'd1;
    assign w_h_next = w_hs_fall ? '0 : w_h_inc;
    assign w_v_next = w_fs ? '0 : (w_hs_fall ? w_v_inc : r_v_cnt);

    // Line/frame conformance; the first line and first complete frame are not judged
    assign w_line_bad   = w_hs_fall & r_line_meas & (w_h_inc != 10'(H_TOTAL));
    assign w_frame_meas = w_fs & (r_fs_seen == 2'd2);
    assign w_frame_bad  = w_frame_meas & (w_v_inc != 10'(V_TOTAL));
    assign w_frame_good = w_frame_meas & ~w_frame_bad & ~r_bad_line_seen & ~w_line_bad;

    // Window and coordinates use the counter values that describe the pixel now in the sync stage
    assign w_in_win = (w_h_next >= 10'(H_DISP_START)) && (w_h_next < 10'(H_DISP_END)) &&
                      (w_v_next >= 10'(V_DISP_START)) && (w_v_next < 10'(V_DISP_END));
    assign w_x      = w_h_next - 10'(H_DISP_START);
    assign w_y      = 9'(w_v_next - 10'(V_DISP_START));

    assign w_good_inc = r_good_cnt + 4'd1;

    // Two-flop synchroniser for syncs and colour, every clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_s1  <= 1'b1;
            r_hs_s2  <= 1'b1;
            r_vs_s1  <= 1'b1;
            r_vs_s2  <= 1'b1;
            r_rgb_s1 <= '0;
            r_rgb_s2 <= '0;
        end else begin
            r_hs_s1  <= hsync_in;
            r_hs_s2  <= r_hs_s1;
            r_vs_s1  <= vsync_in;
            r_vs_s2  <= r_vs_s1;
            r_rgb_s1 <= rgb_in;
            r_rgb_s2 <= r_rgb_s1;
        end
    end

    // Counters, length measurement and frame bookkeeping on pixel ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_prev       <= 1'b1;
            r_vs_prev       <= 1'b1;
            r_vs_pend       <= 1'b0;
            r_line_meas     <= 1'b0;
            r_bad_line_seen <= 1'b0;
            r_fs_seen       <= 2'd0;
            r_h_cnt         <= CNT_MAX;
            r_v_cnt         <= CNT_MAX;
            r_line_len      <= '0;
            r_frame_len     <= '0;
            r_frame_start   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (clk_25MHz) begin
                r_hs_prev     <= r_hs_s2;
                r_vs_prev     <= r_vs_s2;
                r_h_cnt       <= w_h_next;
                r_v_cnt       <= w_v_next;
                r_frame_start <= w_fs;
                if (w_hs_fall) begin
                    r_line_len  <= w_h_inc;
                    r_line_meas <= 1'b1;
                end
                if (w_fs) begin
                    r_vs_pend   <= 1'b0;
                    r_frame_len <= w_v_inc;
                    if (r_fs_seen != 2'd2)
                        r_fs_seen <= r_fs_seen + 2'd1;
                end else if (w_vs_fall) begin
                    r_vs_pend <= 1'b1;
                end
                if (w_fs)
                    r_bad_line_seen <= 1'b0;
                else if (w_line_bad)
                    r_bad_line_seen <= 1'b1;
            end
        end
    end

    // Registered pixel outputs; x/y hold outside valid pixels, colour forced to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_rgb_out     <= '0;
            r_pixel_valid <= 1'b0;
        end else if (clk_25MHz) begin
            r_pixel_valid <= w_in_win & r_locked;
            if (w_in_win && r_locked) begin
                r_x       <= w_x;
                r_y       <= w_y;
                r_rgb_out <= r_rgb_s2;
            end else begin
                r_rgb_out <= '0;
            end
        end
    end

    // Lock FSM: count consecutive good frames, drop out on any bad line or frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_UNLOCKED;
            r_good_cnt   <= '0;
            r_locked     <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_sync_error <= 1'b0;
            if (clk_25MHz) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_line_bad || w_frame_bad) begin
                            r_good_cnt <= '0;
                        end else if (w_frame_good) begin
                            if (w_good_inc >= 4'(LOCK_FRAMES)) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= w_good_inc;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_line_bad || w_frame_bad) begin
                            r_state      <= ST_UNLOCKED;
                            r_locked     <= 1'b0;
                            r_sync_error <= 1'b1;
                            r_good_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state  <= ST_UNLOCKED;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_RX_FRAME_CHECKSUM_EN
    logic [15:0] r_acc, r_checksum;
    logic [15:0] w_acc_next;

    assign w_acc_next = r_acc + (r_pixel_valid ? {4'b0, r_rgb_out} : 16'd0);

    // Per-frame sum of displayed pixels, published at each frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_checksum <= '0;
        end else if (clk_25MHz) begin
            if (w_fs) begin
                r_checksum <= w_acc_next;
                r_acc      <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign x           = r_x;
    assign y           = r_y;
    assign rgb_out     = r_rgb_out;
    assign pixel_valid = r_pixel_valid;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign sync_error  = r_sync_error;
    assign line_len    = r_line_len;
    assign frame_len   = r_frame_len;

endmodule
